vector_seq: RTL and testbench
=============================

# vector_seq

Upstream sequencer for the `linedraw` rasteriser. On each `frame_start` it walks a vector list held in a synchronous-read memory, keeps a pen position, and issues one line command per draw entry. It drives `go`/`stax`/`stay`/`endx`/`endy` into the line drawer, uses `busy` for flow control, and pulses `frame_done` when the list is exhausted.

## Interface

Parameters:

- `ADDR_W`, 8: vector memory address width.
- `BASE_ADDR`, 0: address of the first list entry.

Ports:

- `clk`, in, 1: system clock. All logic is on the rising edge.
- `rst`, in, 1: reset. Synchronous, active-high.
- `frame_start`, in, 1: one-cycle pulse that starts a list pass.
- `mem_addr`, out, `ADDR_W`: vector memory read address.
- `mem_data`, in, 18: entry `{eol, draw, x[7:0], y[7:0]}`. Valid the cycle after `mem_addr` is presented.
- `busy`, in, 1: line drawer busy flag.
- `go`, out, 1: line start pulse.
- `stax`, `stay`, `endx`, `endy`, out, 8 each: line endpoints, registered.
- `active`, out, 1: high whenever the state is not IDLE.
- `frame_done`, out, 1: one-cycle pulse at the end of a pass.
- `list_err`, out, 1: one-cycle pulse when the pass ends by address overflow.

## Operation

- States: IDLE, FETCH, LATCH, ISSUE, HOLD, WAIT, DONE.
- `mem_addr` is the pointer register `ptr`, output directly.
- **IDLE**
  - On `frame_start`: `ptr <= BASE_ADDR`, pen `<= (0,0)`, go to FETCH.
  - Otherwise stay in IDLE.
- **FETCH**
  - Memory samples `ptr`. Always go to LATCH.
- **LATCH** (`mem_data` valid). Let `last = eol | (ptr == 2^ADDR_W-1)`.
  - If `draw=1`:
    - Load `stax/stay <=` pen and `endx/endy <= (x,y)`.
    - Set pen `<= (x,y)`.
    - Go to ISSUE.
  - If `draw=0` (move):
    - Set pen `<= (x,y)`. Endpoint outputs are unchanged.
    - If `last`, go to DONE. Otherwise `ptr <= ptr+1` and go to FETCH.
- **ISSUE**
  - `go=1` for exactly this cycle. Go to HOLD.
- **HOLD**
  - Single cycle during which `busy` is ignored; the drawer raises it one cycle after `go`. Go to WAIT.
- **WAIT**
  - While `busy=1`, stay.
  - When `busy=0`: if the latched `last` is set, go to DONE; otherwise `ptr <= ptr+1` and go to FETCH.
- **DONE**
  - `frame_done=1`.
  - `list_err=1` if the pass ended on `ptr == 2^ADDR_W-1` with `eol=0`.
  - Go to IDLE.
- Arithmetic and width rules:
  - `ptr` never wraps. Reaching the all-ones address terminates the pass.
  - The pen is unsigned 8-bit with no arithmetic.
- Endpoint hold rule: `stax..endy` are held constant from ISSUE until the next LATCH of a draw entry. The drawer reads them combinationally for the whole line.
- `frame_start` outside IDLE is ignored and not queued. That includes the DONE cycle.
- A draw entry equal to the pen position is still issued as a zero-length line.

## Timing

- Reset values:
  - `go`, `active`, `frame_done`, `list_err` = 0.
  - `stax`, `stay`, `endx`, `endy` = 0.
  - `mem_addr` = `BASE_ADDR`.
  - Pen = (0,0). State = IDLE.
- `rst` mid-pass:
  - Next cycle is IDLE with all of the above values.
  - No `frame_done` pulse.
  - A line already started in the drawer is not cancelled, since the drawer has no reset.
- `frame_start` at edge t: FETCH in cycle t+1, LATCH in cycle t+2.
- Move entry: 2 cycles (FETCH, LATCH).
- Draw entry: FETCH, LATCH, ISSUE, HOLD, then WAIT for W≥1 cycles. Total 4+W cycles.
- Drawer handshake:
  - The drawer sees `go` in ISSUE and asserts `busy` from HOLD onwards.
  - It deasserts `busy` in its completion cycle.
  - The first WAIT cycle with `busy=0` is the exit cycle.
- Back-to-back draws: the next `go` comes exactly 3 cycles after the WAIT exit (FETCH, LATCH, ISSUE).
- `frame_done` is asserted in the cycle after the exit from the final LATCH or WAIT.
- `active` is low in the cycle after DONE.

## Test plan

1. **Two-draw list.**
   - List: move(10,10); draw(20,10); draw(20,30,eol). Drawer model holds `busy` for 5 cycles.
   - Expect exactly two `go` pulses.
   - First line (10,10)->(20,10); second line (20,10)->(20,30).
   - One `frame_done`, `list_err=0`.
2. **Timing check.**
   - List: move(0,0,eol).
   - Expect `frame_start` at t, LATCH at t+2, `frame_done` at t+3, no `go`, `active` low at t+4.
3. **Overflow.**
   - `ADDR_W=3`, 8 move entries, none with `eol`.
   - Expect `mem_addr` to step 0..7 with no wrap, then `frame_done` and `list_err` in the same cycle.
4. **Busy stall and restart.**
   - Drawer holds `busy` for 40 cycles.
   - Endpoint outputs stay constant throughout.
   - `frame_start` pulses during WAIT are ignored.
   - A pulse after `frame_done` restarts from `BASE_ADDR` with pen (0,0).
5. **Reset mid-WAIT.**
   - Assert `rst` for 1 cycle during WAIT.
   - Next cycle: all outputs at reset values, state IDLE, no `frame_done`.
   - A following `frame_start` runs a clean pass.
6. **Zero-length and immediate busy drop.**
   - List: draw(0,0,eol) with pen (0,0). Drawer asserts `busy` for 1 cycle only.
   - Expect a single `go` with `stax=endx=0` and `stay=endy=0`.
   - WAIT lasts 1 cycle, then `frame_done`.

Source files
------------

// File: rtl/vector_seq.sv
// Vector-list sequencer feeding the linedraw rasteriser: walks a list of
// {eol, draw, x, y} entries per frame, tracks the pen and issues one line per draw entry.
module vector_seq #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [17:0]       mem_data,
  input  logic              busy,
  output logic              go,
  output logic [7:0]        stax,
  output logic [7:0]        stay,
  output logic [7:0]        endx,
  output logic [7:0]        endy,
  output logic              active,
  output logic              frame_done,
  output logic              list_err
);

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_ISSUE,
    S_HOLD,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [7:0]        pen_x;
  logic [7:0]        pen_y;
  logic              last_eol;
  logic              last_ovf;

  logic       ent_eol;
  logic       ent_draw;
  logic [7:0] ent_x;
  logic [7:0] ent_y;
  logic       at_end;

  assign ent_eol  = mem_data[17];
  assign ent_draw = mem_data[16];
  assign ent_x    = mem_data[15:8];
  assign ent_y    = mem_data[7:0];
  assign at_end   = (ptr == LAST_ADDR);
  assign mem_addr = ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      ptr        <= BASE;
      pen_x      <= 8'd0;
      pen_y      <= 8'd0;
      last_eol   <= 1'b0;
      last_ovf   <= 1'b0;
      go         <= 1'b0;
      active     <= 1'b0;
      frame_done <= 1'b0;
      list_err   <= 1'b0;
      stax       <= 8'd0;
      stay       <= 8'd0;
      endx       <= 8'd0;
      endy       <= 8'd0;
    end else begin
      go         <= 1'b0;
      frame_done <= 1'b0;
      list_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (frame_start) begin
            ptr    <= BASE;
            pen_x  <= 8'd0;
            pen_y  <= 8'd0;
            active <= 1'b1;
            state  <= S_FETCH;
          end
        end
        S_FETCH: state <= S_LATCH;
        S_LATCH: begin
          // Termination is remembered here so WAIT can decide without re-reading memory.
          pen_x    <= ent_x;
          pen_y    <= ent_y;
          last_eol <= ent_eol;
          last_ovf <= at_end;
          if (ent_draw) begin
            stax  <= pen_x;
            stay  <= pen_y;
            endx  <= ent_x;
            endy  <= ent_y;
            go    <= 1'b1;
            state <= S_ISSUE;
          end else if (ent_eol || at_end) begin
            frame_done <= 1'b1;
            list_err   <= at_end & ~ent_eol;
            state      <= S_DONE;
          end else begin
            ptr   <= ptr + ADDR_W'(1);
            state <= S_FETCH;
          end
        end
        S_ISSUE: state <= S_HOLD;
        // The drawer only raises busy one cycle after go, so HOLD never samples it.
        S_HOLD:  state <= S_WAIT;
        S_WAIT: begin
          if (!busy) begin
            if (last_eol || last_ovf) begin
              frame_done <= 1'b1;
              list_err   <= last_ovf & ~last_eol;
              state      <= S_DONE;
            end else begin
              ptr   <= ptr + ADDR_W'(1);
              state <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          active <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          active <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_seq.sv
// Randomised and directed bench for vector_seq with a list-level reference model.
module tb_vector_seq;

  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_start = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [17:0]   mem_data = 18'd0;
  logic          busy = 1'b0;
  logic          go;
  logic [7:0]    stax, stay, endx, endy;
  logic          active, frame_done, list_err;

  vector_seq #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .mem_addr(mem_addr),
    .mem_data(mem_data), .busy(busy), .go(go), .stax(stax), .stay(stay),
    .endx(endx), .endy(endy), .active(active), .frame_done(frame_done),
    .list_err(list_err)
  );

  always #5 clk = ~clk;

  logic [17:0] mem [8];
  int          busy_len = 1;
  int          bcnt = 0;

  // Synchronous-read vector memory and a drawer that holds busy for busy_len cycles after go.
  always @(posedge clk) mem_data <= mem[mem_addr];
  always @(posedge clk) begin
    if (go) begin
      busy <= 1'b1;
      bcnt <= busy_len - 1;
    end else if (bcnt > 0) begin
      bcnt <= bcnt - 1;
    end else begin
      busy <= 1'b0;
    end
  end

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_lines[$];
  int          exp_cycles;
  int          exp_last;
  logic        exp_err;

  function automatic logic [17:0] ent(input bit eol, input bit draw, input int x, input int y);
    return {eol, draw, 8'(x), 8'(y)};
  endfunction

  task automatic model(input int nb);
    logic [7:0]  px;
    logic [7:0]  py;
    logic [17:0] e;
    px = 8'd0; py = 8'd0;
    exp_lines.delete();
    exp_cycles = 0; exp_last = 0; exp_err = 1'b0;
    for (int a = 0; a < 8; a++) begin
      e = mem[a];
      if (e[16]) begin
        exp_lines.push_back({px, py, e[15:8], e[7:0]});
        exp_cycles += 4 + nb;
      end else begin
        exp_cycles += 2;
      end
      px = e[15:8]; py = e[7:0];
      if (e[17] || a == 7) begin
        exp_last = a;
        exp_err  = ~e[17];
        break;
      end
    end
  endtask

  task automatic run_pass(input string name, input int nb, input bit fs_wait, input bit fs_done);
    logic [31:0] got[$];
    logic [31:0] cur;
    bit          have_line;
    int          done_at, n, hold_bad, addr_bad, act_bad, done_cnt, inject_at;
    logic [AW-1:0] prev_addr, addr_at_done;
    logic        err_at_done, act_after;
    have_line = 0; done_at = -1; n = 0; hold_bad = 0; addr_bad = 0; act_bad = 0;
    done_cnt = 0; inject_at = -1; err_at_done = 0; addr_at_done = '0; act_after = 1'b1;
    cur = '0;
    busy_len = nb;
    model(nb);
    @(negedge clk); frame_start = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (mem_addr !== 3'd0)
      begin failures++; $display("FAIL %s start_addr got=%0d exp=0", name, mem_addr); end
    prev_addr = mem_addr;
    while (n < 3000) begin
      frame_start = 1'b0;
      if (mem_addr !== prev_addr) begin
        if (int'(mem_addr) != int'(prev_addr) + 1) addr_bad++;
        prev_addr = mem_addr;
      end
      if (go) begin
        cur = {stax, stay, endx, endy};
        got.push_back(cur);
        have_line = 1;
        if (fs_wait) inject_at = n + 4;
      end else if (have_line && {stax, stay, endx, endy} !== cur) begin
        hold_bad++;
      end
      if (frame_done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = n; err_at_done = list_err; addr_at_done = mem_addr;
          if (fs_done) frame_start = 1'b1;
        end
      end else if (list_err) begin
        act_bad++;
      end
      if (done_at < 0 && !active) act_bad++;
      if (n == inject_at) frame_start = 1'b1;
      if (done_at >= 0 && n == done_at + 1) act_after = active;
      if (done_at >= 0 && n >= done_at + 4) break;
      @(posedge clk); #1;
      n++;
    end
    frame_start = 1'b0;
    checks++;
    if (done_at != exp_cycles)
      begin failures++; $display("FAIL %s done_cycle got=%0d exp=%0d", name, done_at, exp_cycles); end
    checks++;
    if (done_cnt != 1)
      begin failures++; $display("FAIL %s done_count got=%0d exp=1", name, done_cnt); end
    checks++;
    if (err_at_done !== exp_err)
      begin failures++; $display("FAIL %s list_err got=%0b exp=%0b", name, err_at_done, exp_err); end
    checks++;
    if (int'(addr_at_done) != exp_last)
      begin failures++; $display("FAIL %s final_addr got=%0d exp=%0d", name, addr_at_done, exp_last); end
    checks++;
    if (got.size() != exp_lines.size())
      begin failures++; $display("FAIL %s go_count got=%0d exp=%0d", name, got.size(), exp_lines.size()); end
    else
      for (int i = 0; i < got.size(); i++) begin
        checks++;
        if (got[i] !== exp_lines[i])
          begin failures++; $display("FAIL %s line%0d got=%h exp=%h", name, i, got[i], exp_lines[i]); end
      end
    checks++;
    if (hold_bad != 0)
      begin failures++; $display("FAIL %s endpoint_hold changes=%0d exp=0", name, hold_bad); end
    checks++;
    if (addr_bad != 0)
      begin failures++; $display("FAIL %s addr_step bad=%0d exp=0", name, addr_bad); end
    checks++;
    if (act_bad != 0)
      begin failures++; $display("FAIL %s active_or_err bad=%0d exp=0", name, act_bad); end
    checks++;
    if (act_after !== 1'b0)
      begin failures++; $display("FAIL %s active_after_done got=%0b exp=0", name, act_after); end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({go, active, frame_done, list_err} !== 4'b0000 ||
        {stax, stay, endx, endy} !== 32'd0 || mem_addr !== 3'd0)
      begin
        failures++;
        $display("FAIL %s reset_outputs got go=%0b act=%0b fd=%0b le=%0b ep=%h addr=%0d exp all zero",
                 name, go, active, frame_done, list_err, {stax, stay, endx, endy}, mem_addr);
      end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 8; i++) mem[i] = ent(1, 0, 0, 0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk); rst = 1'b0;
    repeat (4) @(posedge clk);
    #1 check_reset_outputs("idle_no_start");
  endtask

  task automatic test_two_draw();
    mem[0] = ent(0, 0, 10, 10);
    mem[1] = ent(0, 1, 20, 10);
    mem[2] = ent(1, 1, 20, 30);
    run_pass("two_draw", 5, 0, 0);
  endtask

  task automatic test_timing();
    mem[0] = ent(1, 0, 0, 0);
    run_pass("timing", 3, 0, 0);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) mem[i] = ent(0, 0, i * 3, 255 - i);
    run_pass("overflow", 2, 0, 0);
  endtask

  task automatic test_busy_stall();
    mem[0] = ent(0, 1, 5, 6);
    mem[1] = ent(1, 1, 7, 8);
    run_pass("stall", 40, 1, 1);
    mem[0] = ent(1, 1, 9, 9);
    run_pass("restart", 2, 0, 0);
  endtask

  task automatic test_reset_mid_wait();
    int  n;
    int  fd_seen;
    mem[0] = ent(1, 1, 50, 60);
    busy_len = 30;
    @(negedge clk); frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    n = 0;
    while (!go && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (!go) begin failures++; $display("FAIL rst_mid go_seen got=0 exp=1"); end
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check_reset_outputs("rst_mid");
    fd_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (frame_done || active) fd_seen++;
    end
    checks++;
    if (fd_seen != 0)
      begin failures++; $display("FAIL rst_mid stray_activity got=%0d exp=0", fd_seen); end
    mem[0] = ent(0, 1, 3, 4);
    mem[1] = ent(1, 1, 100, 200);
    run_pass("after_rst", 2, 0, 0);
  endtask

  task automatic test_zero_len();
    mem[0] = ent(1, 1, 0, 0);
    run_pass("zero_len", 1, 0, 0);
  endtask

  task automatic test_random();
    int len;
    for (int t = 0; t < 12; t++) begin
      len = $urandom_range(1, 8);
      for (int i = 0; i < 8; i++)
        mem[i] = ent(0, $urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) mem[len - 1][17] = 1'b1;
      run_pass($sformatf("random%0d", t), $urandom_range(1, 6), 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_two_draw();
    test_timing();
    test_overflow();
    test_busy_stall();
    test_reset_mid_wait();
    test_zero_len();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
